// File: rtl/tdc_readout_sequencer_pkg.sv
// Shared definitions for the TDC readout sequencer: state codes, default delays, timer sizing.
// Latency: n/a (package).
// Backpressure: n/a (package).
package tdc_readout_sequencer_pkg;

  // Default timing, in core clock cycles
  localparam int DEF_RAW_DLY     = 4;  // TOA_Latch -> RawdataWrtEn
  localparam int DEF_ENC_DLY     = 2;  // RawdataWrtEn -> EncdataWrtEn (encoder settle)
  localparam int DEF_CNT_RST_CYC = 2;  // Counter_RSTN low time on arming
  localparam int DEF_DROP_W      = 8;  // dropped-trigger counter width

  // State codes are visible on the debug port, so keep them explicit and stable.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CNTRST   = 3'd1,
    S_ARMED    = 3'd2,
    S_LATCH    = 3'd3,
    S_WAIT_RAW = 3'd4,
    S_WAIT_ENC = 3'd5,
    S_HOLD     = 3'd6,
    S_CLEAR    = 3'd7
  } seqState_t;

  function automatic int maxOf3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // One timer serves all three timed phases, so size it for the longest.
  function automatic int timerWidth(input int rawDly, input int encDly, input int cntRstCyc);
    return $clog2(maxOf3(rawDly, encDly, cntRstCyc) + 1);
  endfunction

endpackage

// File: rtl/tdc_readout_sequencer_timer.sv
// Loadable down-counter with terminal-count flags, shared by the timed sequencer phases.
// Latency: count is registered; tc reflects the current count, tcNext the value after this edge.
// Backpressure: none; loads whenever told and saturates at zero.
//
// Ports:
//   Clk, RSTN   clock and async active-low reset
//   load        load loadVal on this edge (otherwise decrement toward zero)
//   loadVal     value to load; a phase of N cycles loads N-1
//   tc          current count is zero (last cycle of the phase)
//   tcNext      count after this edge will be zero (lets the caller register a last-cycle strobe)
module tdc_readout_sequencer_timer #(
  parameter int W = 3
)(
  input  logic         Clk,
  input  logic         RSTN,
  input  logic         load,
  input  logic [W-1:0] loadVal,
  output logic         tc,
  output logic         tcNext
);

  logic [W-1:0] cnt;
  logic [W-1:0] cntNext;

  always_comb begin
    cntNext = cnt;
    if (load) begin
      cntNext = loadVal;
    end else if (cnt != '0) begin
      cntNext = cnt - W'(1);
    end
  end

  always_ff @(posedge Clk or negedge RSTN) begin
    if (!RSTN) begin
      cnt <= '0;
    end else begin
      cnt <= cntNext;
    end
  end

  assign tc     = (cnt == '0);
  assign tcNext = (cntNext == '0);

endmodule

// File: rtl/tdc_readout_sequencer.sv
// Per-hit sequencer: counter reset, TOA latch, raw/encoded write strobes, result handshake, clear.
// Latency: trigger in cycle T -> TOA_Latch T+1, RawdataWrtEn T+1+RAW_DLY, EncdataWrtEn T+1+RAW_DLY+ENC_DLY, hitValid T+2+RAW_DLY+ENC_DLY.
// Backpressure: hitValid holds until rdReady; triggers arriving while a capture is in flight are dropped and counted.
//
// Ports:
//   Clk, RSTN          clock and async active-low reset
//   enable             slow-control run enable (level); low forces IDLE
//   hit                single-cycle hit pulse
//   selfTest           level; each rising edge is a trigger
//   rdReady            downstream ready for the encoded result
//   Counter_RSTN       ripple counter reset, active low
//   TOA_Latch          one-cycle TOA latch pulse
//   RawdataWrtEn       one-cycle raw register capture strobe
//   EncdataWrtEn       one-cycle encoded register capture strobe
//   ResetFlag          active-low clear of result/flag registers
//   hitValid           encoded result available
//   busy               capture in progress (not IDLE/ARMED)
//   dropCount          saturating count of rejected triggers
//   state              current FSM state (debug)
module tdc_readout_sequencer
  import tdc_readout_sequencer_pkg::*;
#(
  parameter int RAW_DLY     = DEF_RAW_DLY,
  parameter int ENC_DLY     = DEF_ENC_DLY,
  parameter int CNT_RST_CYC = DEF_CNT_RST_CYC,
  parameter int DROP_W      = DEF_DROP_W
)(
  input  logic              Clk,
  input  logic              RSTN,
  input  logic              enable,
  input  logic              hit,
  input  logic              selfTest,
  input  logic              rdReady,
  output logic              Counter_RSTN,
  output logic              TOA_Latch,
  output logic              RawdataWrtEn,
  output logic              EncdataWrtEn,
  output logic              ResetFlag,
  output logic              hitValid,
  output logic              busy,
  output logic [DROP_W-1:0] dropCount,
  output logic [2:0]        state
);

  localparam int CW = timerWidth(RAW_DLY, ENC_DLY, CNT_RST_CYC);
  localparam logic [CW-1:0] RAW_LD = CW'(RAW_DLY - 1);
  localparam logic [CW-1:0] ENC_LD = CW'(ENC_DLY - 1);
  localparam logic [CW-1:0] CNT_LD = CW'(CNT_RST_CYC - 1);

  seqState_t   curState;
  seqState_t   nextState;
  logic        selfTestQ;
  logic        trigger;
  logic        dropTrig;
  logic        tmrLoad;
  logic [CW-1:0] tmrLoadVal;
  logic        tmrTc;
  logic        tmrTcNext;

  // hit and a selfTest rise in the same cycle collapse into one trigger.
  assign trigger  = hit | (selfTest & ~selfTestQ);
  assign dropTrig = trigger && (curState inside {S_LATCH, S_WAIT_RAW, S_WAIT_ENC, S_HOLD, S_CLEAR});

  always_comb begin
    nextState = curState;
    case (curState)
      S_IDLE:     nextState = S_CNTRST;
      S_CNTRST:   if (tmrTc)   nextState = S_ARMED;
      S_ARMED:    if (trigger) nextState = S_LATCH;
      S_LATCH:    nextState = S_WAIT_RAW;
      S_WAIT_RAW: if (tmrTc)   nextState = S_WAIT_ENC;
      S_WAIT_ENC: if (tmrTc)   nextState = S_HOLD;
      // hitValid is high for the whole of HOLD, so rdReady alone completes the handshake.
      S_HOLD:     if (rdReady) nextState = S_CLEAR;
      S_CLEAR:    nextState = S_ARMED;
      default:    nextState = S_IDLE;
    endcase
    // Dropping enable wins from any state; since every output is derived from
    // nextState, any pending strobe is suppressed along with it.
    if (!enable) nextState = S_IDLE;
  end

  // Reload the timer on every state change with the length of the phase being entered.
  always_comb begin
    tmrLoad    = (nextState != curState);
    tmrLoadVal = '0;
    case (nextState)
      S_CNTRST:   tmrLoadVal = CNT_LD;
      S_WAIT_RAW: tmrLoadVal = RAW_LD;
      S_WAIT_ENC: tmrLoadVal = ENC_LD;
      default:    tmrLoadVal = '0;
    endcase
  end

  tdc_readout_sequencer_timer #(
    .W (CW)
  ) uTimer (
    .Clk     (Clk),
    .RSTN    (RSTN),
    .load    (tmrLoad),
    .loadVal (tmrLoadVal),
    .tc      (tmrTc),
    .tcNext  (tmrTcNext)
  );

  // Outputs are registered from nextState so they line up with the state they belong to.
  // The write strobes use tmrTcNext to land in the final cycle of their wait phase.
  always_ff @(posedge Clk or negedge RSTN) begin
    if (!RSTN) begin
      curState     <= S_IDLE;
      selfTestQ    <= 1'b0;
      Counter_RSTN <= 1'b0;
      TOA_Latch    <= 1'b0;
      RawdataWrtEn <= 1'b0;
      EncdataWrtEn <= 1'b0;
      ResetFlag    <= 1'b0;
      hitValid     <= 1'b0;
      busy         <= 1'b0;
      dropCount    <= '0;
    end else begin
      curState     <= nextState;
      selfTestQ    <= selfTest;
      Counter_RSTN <= !(nextState inside {S_IDLE, S_CNTRST});
      TOA_Latch    <= (nextState == S_LATCH);
      RawdataWrtEn <= (nextState == S_WAIT_RAW) && tmrTcNext;
      EncdataWrtEn <= (nextState == S_WAIT_ENC) && tmrTcNext;
      ResetFlag    <= !(nextState inside {S_IDLE, S_CNTRST, S_CLEAR});
      hitValid     <= (nextState == S_HOLD);
      busy         <= !(nextState inside {S_IDLE, S_ARMED});
      if (dropTrig && (dropCount != '1)) begin
        dropCount <= dropCount + DROP_W'(1);
      end
    end
  end

  assign state = curState;

endmodule

// File: tb/tb_tdc_readout_sequencer.sv
// Scoreboard bench for tdc_readout_sequencer: stimulus queues expected strobe cycles,
// a negedge monitor matches every observed strobe/handshake against the queue.
// A second instance with a 2-bit drop counter shares all inputs to exercise saturation.
module tb_tdc_readout_sequencer;
  import tdc_readout_sequencer_pkg::*;

  localparam int EV_TOA = 0;
  localparam int EV_RAW = 1;
  localparam int EV_ENC = 2;
  localparam int EV_HV  = 3;
  localparam int EV_HS  = 4;
  localparam int EV_CLR = 5;

  typedef struct {
    int kind;
    int cyc;
  } expEv_t;

  logic       Clk = 1'b0;
  logic       RSTN = 1'b0;
  logic       enable = 1'b0;
  logic       hit = 1'b0;
  logic       selfTest = 1'b0;
  logic       rdReady = 1'b0;

  logic       Counter_RSTN, TOA_Latch, RawdataWrtEn, EncdataWrtEn, ResetFlag, hitValid, busy;
  logic [7:0] dropCount;
  logic [2:0] state;

  logic       satCounterRstn, satToaLatch, satRawEn, satEncEn, satResetFlag, satHitValid, satBusy;
  logic [1:0] satDropCount;
  logic [2:0] satState;

  int     cyc = 0;
  int     nChecks = 0;
  int     nErrors = 0;
  logic   hvPrev = 1'b0;
  expEv_t expQ[$];

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  tdc_readout_sequencer dut (
    .Clk(Clk), .RSTN(RSTN), .enable(enable), .hit(hit), .selfTest(selfTest), .rdReady(rdReady),
    .Counter_RSTN(Counter_RSTN), .TOA_Latch(TOA_Latch), .RawdataWrtEn(RawdataWrtEn),
    .EncdataWrtEn(EncdataWrtEn), .ResetFlag(ResetFlag), .hitValid(hitValid), .busy(busy),
    .dropCount(dropCount), .state(state)
  );

  tdc_readout_sequencer #(.DROP_W(2)) dutSat (
    .Clk(Clk), .RSTN(RSTN), .enable(enable), .hit(hit), .selfTest(selfTest), .rdReady(rdReady),
    .Counter_RSTN(satCounterRstn), .TOA_Latch(satToaLatch), .RawdataWrtEn(satRawEn),
    .EncdataWrtEn(satEncEn), .ResetFlag(satResetFlag), .hitValid(satHitValid), .busy(satBusy),
    .dropCount(satDropCount), .state(satState)
  );

  function automatic string evName(input int k);
    case (k)
      EV_TOA:  return "TOA_Latch";
      EV_RAW:  return "RawdataWrtEn";
      EV_ENC:  return "EncdataWrtEn";
      EV_HV:   return "hitValid_rise";
      EV_HS:   return "handshake";
      default: return "clear";
    endcase
  endfunction

  task automatic chk(input string name, input int actual, input int expected);
    nChecks++;
    if (actual != expected) begin
      nErrors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  task automatic pushEv(input int kind, input int c);
    expEv_t e;
    e.kind = kind;
    e.cyc  = c;
    expQ.push_back(e);
  endtask

  // Expected strobes of one full capture triggered in cycle t (default delays 4/2).
  task automatic pushCapture(input int t, input int hsCyc);
    pushEv(EV_TOA, t + 1);
    pushEv(EV_RAW, t + 5);
    pushEv(EV_ENC, t + 7);
    pushEv(EV_HV,  t + 8);
    pushEv(EV_HS,  hsCyc);
    pushEv(EV_CLR, hsCyc + 1);
  endtask

  task automatic scoreEvent(input int kind);
    int idx;
    idx = -1;
    for (int i = 0; i < expQ.size(); i++) begin
      if (expQ[i].kind == kind) begin
        idx = i;
        break;
      end
    end
    nChecks++;
    if (idx < 0) begin
      nErrors++;
      $display("FAIL unexpected_%s: seen at cycle %0d, expected none", evName(kind), cyc);
    end else begin
      if (expQ[idx].cyc != cyc) begin
        nErrors++;
        $display("FAIL %s_cycle: got cycle %0d, expected cycle %0d", evName(kind), cyc, expQ[idx].cyc);
      end
      expQ.delete(idx);
    end
  endtask

  // Monitor: sample mid-cycle, every strobe cycle must match a queued expectation.
  always @(negedge Clk) begin
    if (!RSTN) begin
      hvPrev <= 1'b0;
    end else begin
      if (TOA_Latch)              scoreEvent(EV_TOA);
      if (RawdataWrtEn)           scoreEvent(EV_RAW);
      if (EncdataWrtEn)           scoreEvent(EV_ENC);
      if (hitValid && !hvPrev)    scoreEvent(EV_HV);
      if (hitValid && rdReady)    scoreEvent(EV_HS);
      if (!ResetFlag && Counter_RSTN) scoreEvent(EV_CLR);
      hvPrev <= hitValid;
    end
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic waitCyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic pulseHitAt(input int c);
    waitCyc(c);
    hit = 1'b1;
    tick();
    hit = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time %0t reached limit 100000 without finishing", $time);
    $fatal(1);
  end

  initial begin
    int e, b, b2, c, f, d;

    // Reset state
    repeat (2) tick();
    chk("rst_Counter_RSTN", int'(Counter_RSTN), 0);
    chk("rst_ResetFlag", int'(ResetFlag), 0);
    chk("rst_strobes", int'({TOA_Latch, RawdataWrtEn, EncdataWrtEn}), 0);
    chk("rst_hitValid", int'(hitValid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_dropCount", int'(dropCount), 0);
    chk("rst_state", int'(state), 0);
    chk("rst_sat_outputs", int'({satCounterRstn, satToaLatch, satRawEn, satEncEn, satResetFlag,
                                 satHitValid, satBusy, satDropCount, satState}), 0);
    tick();
    RSTN = 1'b1;
    tick();

    // 1: arming sequence
    enable = 1'b1;
    e = cyc;
    tick();
    chk("arm_state_cntrst", int'(state), 1);
    chk("arm_Counter_RSTN_c1", int'(Counter_RSTN), 0);
    tick();
    chk("arm_Counter_RSTN_c2", int'(Counter_RSTN), 0);
    tick();
    chk("arm_state_armed", int'(state), 2);
    chk("arm_Counter_RSTN_c3", int'(Counter_RSTN), 1);
    chk("arm_ResetFlag_c3", int'(ResetFlag), 1);
    chk("arm_busy_c3", int'(busy), 0);

    // 2: default capture, rdReady held high
    rdReady = 1'b1;
    pushCapture(e + 10, e + 18);
    pulseHitAt(e + 10);
    waitCyc(e + 12);
    chk("cap_busy", int'(busy), 1);
    waitCyc(e + 19);
    chk("cap_clear_ResetFlag", int'(ResetFlag), 0);
    chk("cap_clear_hitValid", int'(hitValid), 0);
    waitCyc(e + 20);
    chk("cap_rearmed_state", int'(state), 2);
    chk("cap_rearmed_ResetFlag", int'(ResetFlag), 1);
    chk("cap_rearmed_sat_state", int'(satState), 2);

    // 3: backpressure and drops during a capture
    rdReady = 1'b0;
    b = cyc;
    pushCapture(b + 10, b + 30);
    pulseHitAt(b + 10);
    pulseHitAt(b + 12);
    pulseHitAt(b + 20);
    pulseHitAt(b + 25);
    waitCyc(b + 29);
    chk("bp_hitValid_c29", int'(hitValid), 1);
    waitCyc(b + 30);
    chk("bp_hitValid_c30", int'(hitValid), 1);
    rdReady = 1'b1;
    waitCyc(b + 32);
    chk("bp_dropCount", int'(dropCount), 3);
    chk("bp_sat_dropCount", int'(satDropCount), 3);
    chk("bp_state_armed", int'(state), 2);

    // 5b: async reset while in WAIT_ENC
    b2 = cyc + 2;
    pushEv(EV_TOA, b2 + 1);
    pushEv(EV_RAW, b2 + 5);
    pulseHitAt(b2);
    waitCyc(b2 + 6);
    chk("ar_state_wait_enc", int'(state), 5);
    #2;
    RSTN = 1'b0;
    #1;
    chk("ar_Counter_RSTN", int'(Counter_RSTN), 0);
    chk("ar_ResetFlag", int'(ResetFlag), 0);
    chk("ar_strobes", int'({TOA_Latch, RawdataWrtEn, EncdataWrtEn}), 0);
    chk("ar_hitValid", int'(hitValid), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_dropCount", int'(dropCount), 0);
    chk("ar_state", int'(state), 0);
    tick();
    RSTN = 1'b1;
    repeat (4) tick();
    chk("ar_rearmed_state", int'(state), 2);

    // 4: saturation of drop counter, coincident hit + selfTest rise
    c = cyc + 2;
    pushCapture(c, c + 8);
    pulseHitAt(c);
    pulseHitAt(c + 2);
    pulseHitAt(c + 3);
    pulseHitAt(c + 4);
    pulseHitAt(c + 5);
    pulseHitAt(c + 8);
    waitCyc(c + 10);
    chk("sat_state_armed", int'(state), 2);
    chk("sat_dropCount_wide", int'(dropCount), 5);
    chk("sat_dropCount_2b", int'(satDropCount), 3);
    pushCapture(c + 12, c + 20);
    waitCyc(c + 12);
    hit = 1'b1;
    selfTest = 1'b1;
    tick();
    hit = 1'b0;
    waitCyc(c + 23);
    chk("coinc_state_armed", int'(state), 2);
    chk("coinc_dropCount_wide", int'(dropCount), 5);
    chk("coinc_dropCount_2b", int'(satDropCount), 3);
    selfTest = 1'b0;
    tick();

    // selfTest rise alone triggers one capture; holding it high does not retrigger
    f = cyc + 2;
    pushCapture(f, f + 8);
    waitCyc(f);
    selfTest = 1'b1;
    waitCyc(f + 11);
    chk("st_state_armed", int'(state), 2);
    chk("st_dropCount", int'(dropCount), 5);
    selfTest = 1'b0;
    tick();

    // 5a: enable dropped three cycles after a hit
    d = cyc + 2;
    pushEv(EV_TOA, d + 1);
    pulseHitAt(d);
    waitCyc(d + 3);
    enable = 1'b0;
    tick();
    chk("en_state_idle", int'(state), 0);
    chk("en_Counter_RSTN", int'(Counter_RSTN), 0);
    chk("en_ResetFlag", int'(ResetFlag), 0);
    chk("en_hitValid", int'(hitValid), 0);
    chk("en_busy", int'(busy), 0);
    waitCyc(d + 12);
    chk("en_dropCount_held", int'(dropCount), 5);
    chk("en_state_still_idle", int'(state), 0);

    chk("scoreboard_pending", expQ.size(), 0);
    for (int i = 0; i < expQ.size(); i++) begin
      $display("  pending %s expected at cycle %0d", evName(expQ[i].kind), expQ[i].cyc);
    end

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
